// File: rtl/reg_file_wb_8x8_pkg.sv
// Shared widths and address type for the register file and the ALU unit wrappers.
package reg_file_wb_8x8_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_wb_buffer.sv
// One-entry write-back buffer: captures the incoming result and flags read
// ports whose address matches the buffered destination.
module reg_wb_buffer
    import reg_file_wb_8x8_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  reg_data_t in_data,
    input  reg_addr_t in_addr,
    input  logic      write,
    input  reg_addr_t rd1_addr,
    input  reg_addr_t rd2_addr,
    output logic      wb_valid,
    output reg_data_t wb_data,
    output reg_addr_t wb_addr,
    output logic      hit1,
    output logic      hit2
);

    // Capture every accepted write; an idle edge drains the entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_addr  <= '0;
        end else begin
            wb_valid <= write;
            if (write) begin
                wb_data <= in_data;
                wb_addr <= in_addr;
            end
        end
    end

    // Bypass compare, one per read port.
    always_comb begin
        hit1 = wb_valid && (rd1_addr == wb_addr);
        hit2 = wb_valid && (rd2_addr == wb_addr);
    end

endmodule

// File: rtl/reg_file_wb_8x8.sv
// 8x8 register file with a one-stage write-back buffer and bypassed reads.
// A write accepted at one edge is readable during the following cycle and
// lands in the array one edge later. ZERO tracks the last accepted result.
module reg_file_wb_8x8
    import reg_file_wb_8x8_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              ZERO,
    output logic              WB_PENDING
);

    reg_data_t regs [DEPTH];
    logic      wb_valid;
    reg_data_t wb_data;
    reg_addr_t wb_addr;
    logic      hit1;
    logic      hit2;

    reg_wb_buffer u_wb (
        .clk      (CLK),
        .rst_n    (RESET),
        .in_data  (IN),
        .in_addr  (INADDRESS),
        .write    (WRITE),
        .rd1_addr (OUT1ADDRESS),
        .rd2_addr (OUT2ADDRESS),
        .wb_valid (wb_valid),
        .wb_data  (wb_data),
        .wb_addr  (wb_addr),
        .hit1     (hit1),
        .hit2     (hit2)
    );

    // Commit the buffered entry; reset clears the array and drops the entry.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // ZERO follows accepted writes only and holds across idle edges.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ZERO <= 1'b0;
        end else if (WRITE) begin
            ZERO <= (IN == '0);
        end
    end

    // Read ports prefer the buffered value over the array.
    always_comb begin
        OUT1       = hit1 ? wb_data : regs[OUT1ADDRESS];
        OUT2       = hit2 ? wb_data : regs[OUT2ADDRESS];
        WB_PENDING = wb_valid;
    end

endmodule

// File: tb/tb_reg_file_wb_8x8.sv
// Bench for reg_file_wb_8x8: directed scenarios plus randomized traffic
// against an architectural model where a write is visible right after its edge.
module tb_reg_file_wb_8x8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] OUT1;
    logic [7:0] OUT2;
    logic       ZERO;
    logic       WB_PENDING;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_reg [8];
    logic       model_zero;
    logic       model_pend;

    reg_file_wb_8x8 dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN          (IN),
        .INADDRESS   (INADDRESS),
        .WRITE       (WRITE),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .OUT1        (OUT1),
        .OUT2        (OUT2),
        .ZERO        (ZERO),
        .WB_PENDING  (WB_PENDING)
    );

    always #5 CLK = ~CLK;

    // Drive one edge and advance the architectural model; sample #1 after.
    task automatic step(input logic rst, input logic wr, input logic [2:0] a, input logic [7:0] d);
        @(negedge CLK);
        RESET     = rst;
        WRITE     = wr;
        INADDRESS = a;
        IN        = d;
        @(posedge CLK);
        if (!rst) begin
            for (int i = 0; i < 8; i++) model_reg[i] = 8'h00;
            model_zero = 1'b0;
            model_pend = 1'b0;
        end else begin
            if (wr) begin
                model_reg[a] = d;
                model_zero   = (d == 8'h00);
            end
            model_pend = wr;
        end
        #1;
    endtask

    task automatic peek(input logic [2:0] a1, input logic [2:0] a2);
        OUT1ADDRESS = a1;
        OUT2ADDRESS = a2;
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(i * 2 + 1), 8'($urandom_range(1, 255)));
        step(1'b0, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            peek(3'(i), 3'(7 - i));
            checks++;
            if (OUT1 !== 8'h00 || OUT2 !== 8'h00) begin
                errors++;
                $display("FAIL reset_read addr=%0d OUT1=%h OUT2=%h expected 00/00", i, OUT1, OUT2);
            end
        end
        checks++;
        if (ZERO !== 1'b0 || WB_PENDING !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags ZERO=%b WB_PENDING=%b expected 0/0", ZERO, WB_PENDING);
        end
    endtask

    task automatic test_write_read;
        peek(3'd3, 3'd0);
        step(1'b1, 1'b1, 3'd3, 8'h5A);
        checks++;
        if (OUT1 !== 8'h5A || WB_PENDING !== 1'b1) begin
            errors++;
            $display("FAIL write_read_bypass OUT1=%h pend=%b expected 5a/1", OUT1, WB_PENDING);
        end
        step(1'b1, 1'b0, 3'd0, 8'h00);
        checks++;
        if (OUT1 !== 8'h5A || WB_PENDING !== 1'b0) begin
            errors++;
            $display("FAIL write_read_array OUT1=%h pend=%b expected 5a/0", OUT1, WB_PENDING);
        end
    endtask

    task automatic test_back_to_back;
        peek(3'd0, 3'd2);
        step(1'b1, 1'b1, 3'd2, 8'h11);
        checks++;
        if (OUT2 !== 8'h11) begin
            errors++;
            $display("FAIL b2b_first OUT2=%h expected 11", OUT2);
        end
        step(1'b1, 1'b1, 3'd2, 8'h22);
        checks++;
        if (OUT2 !== 8'h22) begin
            errors++;
            $display("FAIL b2b_second OUT2=%h expected 22", OUT2);
        end
        step(1'b1, 1'b0, 3'd0, 8'h00);
        peek(3'd2, 3'd2);
        checks++;
        if (OUT1 !== 8'h22 || OUT2 !== 8'h22 || WB_PENDING !== 1'b0) begin
            errors++;
            $display("FAIL b2b_array OUT1=%h OUT2=%h pend=%b expected 22/22/0", OUT1, OUT2, WB_PENDING);
        end
    endtask

    task automatic test_dual_read;
        logic [7:0] sum;
        step(1'b1, 1'b1, 3'd1, 8'h07);
        step(1'b1, 1'b0, 3'd0, 8'h00);
        peek(3'd1, 3'd4);
        step(1'b1, 1'b1, 3'd4, 8'h09);
        sum = OUT1 + OUT2;
        checks++;
        if (OUT1 !== 8'h07 || OUT2 !== 8'h09 || sum !== 8'h10) begin
            errors++;
            $display("FAIL dual_read OUT1=%h OUT2=%h sum=%h expected 07/09/10", OUT1, OUT2, sum);
        end
        peek(3'd4, 3'd4);
        checks++;
        if (OUT1 !== 8'h09 || OUT2 !== 8'h09) begin
            errors++;
            $display("FAIL dual_bypass OUT1=%h OUT2=%h expected 09/09", OUT1, OUT2);
        end
    endtask

    task automatic test_zero;
        step(1'b1, 1'b1, 3'd0, 8'h00);
        checks++;
        if (ZERO !== 1'b1) begin
            errors++;
            $display("FAIL zero_set ZERO=%b expected 1", ZERO);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 3'(i), 8'h44);
            checks++;
            if (ZERO !== 1'b1) begin
                errors++;
                $display("FAIL zero_hold idle=%0d ZERO=%b expected 1", i, ZERO);
            end
        end
        step(1'b1, 1'b1, 3'd6, 8'h80);
        checks++;
        if (ZERO !== 1'b0) begin
            errors++;
            $display("FAIL zero_clear ZERO=%b expected 0", ZERO);
        end
    endtask

    task automatic test_reset_mid_write;
        peek(3'd5, 3'd5);
        step(1'b1, 1'b1, 3'd5, 8'hFF);
        step(1'b0, 1'b1, 3'd5, 8'hFF);
        checks++;
        if (OUT1 !== 8'h00 || WB_PENDING !== 1'b0 || ZERO !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write OUT1=%h pend=%b ZERO=%b expected 00/0/0", OUT1, WB_PENDING, ZERO);
        end
        step(1'b1, 1'b0, 3'd0, 8'h00);
        checks++;
        if (OUT2 !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_commit OUT2=%h expected 00", OUT2);
        end
    endtask

    task automatic test_random;
        logic       rst, wr;
        logic [2:0] a, r1, r2;
        logic [7:0] d;
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 31) != 0);
            wr  = $urandom_range(0, 2) != 0;
            a   = 3'($urandom_range(0, 7));
            d   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            r1  = ($urandom_range(0, 2) == 0) ? a : 3'($urandom_range(0, 7));
            r2  = 3'($urandom_range(0, 7));
            @(negedge CLK);
            peek(r1, r2);
            checks++;
            if (OUT1 !== model_reg[r1] || OUT2 !== model_reg[r2]) begin
                errors++;
                $display("FAIL rand_pre n=%0d OUT1=%h OUT2=%h expected %h/%h", n, OUT1, OUT2, model_reg[r1], model_reg[r2]);
            end
            step(rst, wr, a, d);
            checks++;
            if (OUT1 !== model_reg[r1] || OUT2 !== model_reg[r2] || ZERO !== model_zero || WB_PENDING !== model_pend) begin
                errors++;
                $display("FAIL rand_post n=%0d OUT1=%h OUT2=%h ZERO=%b pend=%b expected %h/%h/%b/%b",
                         n, OUT1, OUT2, ZERO, WB_PENDING, model_reg[r1], model_reg[r2], model_zero, model_pend);
            end
        end
    endtask

    initial begin
        RESET       = 1'b0;
        WRITE       = 1'b0;
        IN          = 8'h00;
        INADDRESS   = 3'd0;
        OUT1ADDRESS = 3'd0;
        OUT2ADDRESS = 3'd0;
        test_reset;
        test_write_read;
        test_back_to_back;
        test_dual_read;
        test_zero;
        test_reset_mid_write;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
